// File: rtl/tile_deck_shuffler_pkg.sv
// Shared tile-code layout, deck sizing defaults and shuffler FSM encoding.
// The game FSM imports the same field definitions so both sides agree on the layout.
package tile_deck_shuffler_pkg;

  localparam int DEF_N_TILES = 10;
  localparam int DEF_N_COLS  = 4;
  localparam int CODE_W      = 11;

  localparam int ROW_LSB   = 9;
  localparam int ROW_W     = 2;
  localparam int COL_LSB   = 7;
  localparam int COL_W     = 2;
  localparam int COLOR_LSB = 1;
  localparam int COLOR_W   = 6;
  localparam int FLIP_BIT  = 0;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Field order matches the bit offsets above: row in [10:9], flipped in [0].
  typedef struct packed {
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [COLOR_W-1:0] color;
    logic               flip;
  } tile_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHUFFLE,
    ST_STAMP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/tile_deck_shuffler_if.sv
// Start request and deck result bus between the shuffler and the game FSM.
interface tile_deck_shuffler_if
  import tile_deck_shuffler_pkg::*;
#(
  parameter int N_TILES = DEF_N_TILES
) ();

  logic                        start;
  logic                        busy;
  logic                        done;
  logic                        deck_valid;
  logic [N_TILES*CODE_W-1:0]   deck_codes;

  modport master (output start, input busy, done, deck_valid, deck_codes);
  modport slave  (input start, output busy, done, deck_valid, deck_codes);

endinterface

// File: rtl/tile_deck_shuffler_lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift); an all-zero seed is promoted to 1.
module lfsr16
  import tile_deck_shuffler_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  output logic [15:0] o_state
);

  localparam logic [15:0] INIT_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] r_state;

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= INIT_VAL;
    else       r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? LFSR_MASK : 16'h0000);
  end

  assign o_state = r_state;

endmodule

// File: rtl/tile_deck_shuffler.sv
// Builds a paired-colour deck, Fisher-Yates shuffles it one swap per cycle,
// stamps row/col from slot index and publishes it as a flat code bus.
module tile_deck_shuffler
  import tile_deck_shuffler_pkg::*;
#(
  parameter int          N_TILES   = DEF_N_TILES,
  parameter int          N_COLS    = DEF_N_COLS,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  tile_deck_shuffler_if.slave   bus
);

  localparam int IDX_W = 4;

  state_e                   r_state, w_next;
  logic [IDX_W-1:0]         r_idx;
  tile_t [N_TILES-1:0]      r_tiles;
  logic                     r_busy, r_done, r_valid;

  logic [15:0]              w_lfsr;
  logic [IDX_W:0]           w_span;
  logic [12:0]              w_prod;
  logic [IDX_W-1:0]         w_j;
  logic                     w_unused;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .o_state  (w_lfsr)
  );

  // j = (lfsr[7:0] * (i+1)) >> 8 is always <= i, so no rejection loop is needed.
  assign w_span   = {1'b0, r_idx} + (IDX_W+1)'(1);
  assign w_prod   = {5'b0, w_lfsr[7:0]} * {8'b0, w_span};
  assign w_j      = w_prod[8 +: IDX_W];
  assign w_unused = ^{w_prod[12], w_prod[7:0], w_lfsr[15:8]};

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (bus.start) w_next = ST_INIT;
      ST_INIT:    w_next = ST_SHUFFLE;
      ST_SHUFFLE: if (r_idx == IDX_W'(1)) w_next = ST_STAMP;
      ST_STAMP:   w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_tiles <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_INIT: begin
          for (int k = 0; k < N_TILES; k++) begin
            r_tiles[k] <= '{row: '0, col: '0, color: COLOR_W'((k >> 1) + 1), flip: 1'b0};
          end
          r_idx   <= IDX_W'(N_TILES - 1);
          r_valid <= 1'b0;
          r_busy  <= 1'b1;
        end
        ST_SHUFFLE: begin
          // Only colours move; slots keep their identity for the later stamp.
          for (int k = 0; k < N_TILES; k++) begin
            if (IDX_W'(k) == r_idx)
              r_tiles[k].color <= r_tiles[w_j].color;
            else if (IDX_W'(k) == w_j)
              r_tiles[k].color <= r_tiles[r_idx].color;
          end
          r_idx <= r_idx - IDX_W'(1);
        end
        ST_STAMP: begin
          for (int k = 0; k < N_TILES; k++) begin
            r_tiles[k].row  <= ROW_W'(k / N_COLS);
            r_tiles[k].col  <= COL_W'(k % N_COLS);
            r_tiles[k].flip <= 1'b0;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.deck_valid = r_valid;
  assign bus.deck_codes = r_tiles;

endmodule

// File: tb/tb_tile_deck_shuffler.sv
// Directed bench: handshake timeline table plus corner-case sequences,
// decks checked against a bit-level LFSR + Fisher-Yates reference model.
module tb_tile_deck_shuffler;

  localparam int N_T = 10;
  localparam int CW  = 11;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  bit   lfsr0_zero = 1'b0;
  logic [15:0] m_lfsr, m_lfsr0;

  always #5 clk = ~clk;

  tile_deck_shuffler_if #(.N_TILES(N_T)) bus  ();
  tile_deck_shuffler_if #(.N_TILES(N_T)) bus0 ();

  tile_deck_shuffler dut (.CLOCK_50(clk), .reset(reset), .bus(bus));
  tile_deck_shuffler #(.LFSR_SEED(16'h0000)) dut0 (.CLOCK_50(clk), .reset(reset), .bus(bus0));

  function automatic logic [15:0] step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSRs run alongside the DUTs, reset on the same edges.
  always @(posedge clk) begin
    if (reset) begin
      m_lfsr  <= 16'hACE1;
      m_lfsr0 <= 16'h0001;
    end else begin
      m_lfsr  <= step(m_lfsr);
      m_lfsr0 <= step(m_lfsr0);
    end
  end

  always @(negedge clk) begin
    if (!reset && dut0.u_lfsr.o_state == 16'h0000) lfsr0_zero <= 1'b1;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input bit which, input string nm);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(posedge clk); #1;
      if (which ? bus0.done : bus.done) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, seen, 1'b1);
  endtask

  task automatic check_deck(input bit which, input logic [15:0] l0, input string nm);
    logic [15:0]       l;
    logic [5:0]        col [N_T];
    logic [5:0]        t;
    int                j;
    int                cnt [N_T/2+1];
    logic [N_T*CW-1:0] codes;
    logic [CW-1:0]     got, exp;
    bit                inv_ok;
    codes = which ? bus0.deck_codes : bus.deck_codes;
    chk({nm, "_valid"}, which ? bus0.deck_valid : bus.deck_valid, 1'b1);
    for (int k = 0; k < N_T; k++) col[k] = 6'((k >> 1) + 1);
    l = step(l0);
    for (int i = N_T - 1; i >= 1; i--) begin
      j = (int'(l[7:0]) * (i + 1)) >> 8;
      t = col[i]; col[i] = col[j]; col[j] = t;
      l = step(l);
    end
    for (int k = 0; k < N_T; k++) begin
      got = codes[k*CW +: CW];
      exp = {2'(k / 4), 2'(k % 4), col[k], 1'b0};
      chk($sformatf("%s_slot%0d", nm, k), got, exp);
    end
    inv_ok = 1'b1;
    for (int c = 0; c <= N_T/2; c++) cnt[c] = 0;
    for (int k = 0; k < N_T; k++) begin
      got = codes[k*CW +: CW];
      if (got[0]) inv_ok = 1'b0;
      if (got[10:9] != 2'(k / 4) || got[8:7] != 2'(k % 4)) inv_ok = 1'b0;
      if (got[6:1] >= 6'd1 && got[6:1] <= 6'(N_T/2)) cnt[got[6:1]]++;
      else inv_ok = 1'b0;
    end
    for (int c = 1; c <= N_T/2; c++) if (cnt[c] != 2) inv_ok = 1'b0;
    chk({nm, "_invariant"}, inv_ok, 1'b1);
  endtask

  typedef struct {
    bit start;
    bit busy;
    bit done;
    bit valid;
  } vec_t;

  localparam int TBL_N = 16;
  vec_t tbl [TBL_N];

  initial begin
    logic [15:0] l0;
    logic [15:0] l0h;
    int          dones;
    int          p;
    bus.start  = 1'b0;
    bus0.start = 1'b0;

    // Row k: start driven before edge t+k, outputs expected just after that edge.
    for (int k = 0; k < TBL_N; k++)
      tbl[k] = '{start: 1'b0, busy: (k >= 1 && k <= 11), done: (k == 12), valid: (k >= 12)};
    tbl[0].start  = 1'b1;
    tbl[3].start  = 1'b1;
    tbl[12].start = 1'b1;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {bus.busy, bus.done, bus.deck_valid}, 3'b000);
    chk("reset_codes", bus.deck_codes, '0);
    chk("reset_flags_seed0", {bus0.busy, bus0.done, bus0.deck_valid}, 3'b000);
    reset = 1'b0;
    chk("lfsr_seed", dut.u_lfsr.o_state, 16'hACE1);
    chk("lfsr0_seed", dut0.u_lfsr.o_state, 16'h0001);
    @(posedge clk); #1;
    chk("lfsr_step1", dut.u_lfsr.o_state, 16'hE270);
    chk("lfsr0_step1", dut0.u_lfsr.o_state, 16'hB400);

    l0 = '0;
    for (int k = 0; k < TBL_N; k++) begin
      bus.start = tbl[k].start;
      @(posedge clk); #1;
      if (k == 0) l0 = m_lfsr;
      chk($sformatf("timeline%0d", k), {bus.busy, bus.done, bus.deck_valid},
          {tbl[k].busy, tbl[k].done, tbl[k].valid});
    end
    bus.start = 1'b0;
    check_deck(1'b0, l0, "single");

    // Reset lands in the 4th shuffle cycle.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_busy_pre", bus.busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_flags", {bus.busy, bus.done, bus.deck_valid}, 3'b000);
    chk("midrst_codes", bus.deck_codes, '0);
    reset = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    l0 = m_lfsr;
    bus.start = 1'b0;
    wait_done(1'b0, "postrst");
    check_deck(1'b0, l0, "postrst");

    // Held start: a new deck every 13 cycles.
    dones = 0;
    l0h = '0;
    bus.start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      p = c % 13;
      if (p == 0) l0h = m_lfsr;
      if (bus.done) dones++;
      chk($sformatf("held%0d_busy_done", c), {bus.busy, bus.done}, {(p >= 1 && p <= 11), (p == 12)});
      if (p != 0) chk($sformatf("held%0d_valid", c), bus.deck_valid, (p == 12));
      if (p == 12) check_deck(1'b0, l0h, $sformatf("held_deck%0d", c / 13));
    end
    bus.start = 1'b0;
    chk("held_done_count", dones, 3);
    wait_done(1'b0, "held_drain");
    check_deck(1'b0, l0h, "held_deck3");

    bus0.start = 1'b1;
    @(posedge clk); #1;
    l0 = m_lfsr0;
    bus0.start = 1'b0;
    wait_done(1'b1, "seed0");
    check_deck(1'b1, l0, "seed0");
    chk("seed0_never_zero", lfsr0_zero, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
